update_exc_err: RTL and testbench

UPDATE_EXC_ERR -- requirements
Module: update_exc_err

---
 rtl/update_exc_err_pkg.sv | 28 ++
 rtl/update_exc_err_calc.sv | 34 +++
 rtl/update_exc_err.sv | 142 ++++++++++++++
 tb/tb_update_exc_err.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/update_exc_err_pkg.sv
// Shared constants and saturating helpers for the L_exc_err update block.
package update_exc_err_pkg;

  localparam logic [11:0] L_EXC_ERR = 12'h0A0;
  localparam logic [15:0] L_SUBFR   = 16'd40;
  localparam logic [15:0] ZONE_T1   = 16'd40;
  localparam logic [15:0] ZONE_T2   = 16'd80;
  localparam logic [15:0] ZONE_T3   = 16'd120;

  // Any k beyond the last threshold folds into zone 3, so addresses stay in 0..3.
  function automatic logic [1:0] zone_of(input logic [15:0] k);
    logic [1:0] z;
    if (k < ZONE_T1)      z = 2'd0;
    else if (k < ZONE_T2) z = 2'd1;
    else if (k < ZONE_T3) z = 2'd2;
    else                  z = 2'd3;
    return z;
  endfunction

  function automatic logic [31:0] sat32(input logic signed [33:0] v);
    logic [31:0] r;
    if (v > 34'sh0_7FFF_FFFF)      r = 32'h7FFF_FFFF;
    else if (v < 34'sh3_8000_0000) r = 32'h8000_0000;
    else                           r = v[31:0];
    return r;
  endfunction

endpackage

// File: rtl/update_exc_err_calc.sv
// E(x) = L_add(L_shl(Mpy_32_16(hi,lo,gain),1), 0x4000), fully combinational, G.729 saturation.
module exc_err_calc
  import update_exc_err_pkg::*;
(
  input  logic [31:0] i_x,
  input  logic [15:0] i_gain,
  output logic [31:0] o_e
);

  logic signed [15:0] w_hi, w_g;
  logic signed [31:0] w_lo, w_hg, w_lg, w_lgs, w_lmult;
  logic signed [33:0] w_mac, w_dbl, w_add;
  logic        [31:0] w_mpy, w_shl;

  // L_Extract's lo collapses to the low half shifted right: always 0..32767.
  assign w_hi  = $signed(i_x[31:16]);
  assign w_lo  = $signed({16'd0, i_x[15:0]} >> 1);
  assign w_g   = $signed(i_gain);

  assign w_hg    = 32'(w_hi) * 32'(w_g);
  assign w_lmult = (w_hg == 32'sh4000_0000) ? 32'sh7FFF_FFFF : (w_hg <<< 1);

  // lo is non-negative, so mult(lo,gain) can never saturate.
  assign w_lg  = w_lo * 32'(w_g);
  assign w_lgs = w_lg >>> 15;

  assign w_mac = 34'(w_lmult) + 34'(w_lgs) + 34'(w_lgs);
  assign w_mpy = sat32(w_mac);
  assign w_dbl = 34'($signed(w_mpy)) + 34'($signed(w_mpy));
  assign w_shl = sat32(w_dbl);
  assign w_add = 34'($signed(w_shl)) + 34'sh0_0000_4000;
  assign o_e   = sat32(w_add);

endmodule

// File: rtl/update_exc_err.sv
// Scores the L_exc_err zones covered by the current lag, then shifts the
// four-word array down one slot and stores the worst score at slot 0.
module update_exc_err
  import update_exc_err_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [15:0] T0,
  input  logic [15:0] gain_pit,
  output logic [11:0] memReadAddr,
  input  logic [31:0] memIn,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_RD      = 4'd2;
  localparam logic [3:0] S_WAIT    = 4'd3;
  localparam logic [3:0] S_CALC    = 4'd4;
  localparam logic [3:0] S_CMP     = 4'd5;
  localparam logic [3:0] S_SH_RD   = 4'd6;
  localparam logic [3:0] S_SH_WAIT = 4'd7;
  localparam logic [3:0] S_SH_WR   = 4'd8;
  localparam logic [3:0] S_FIN     = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]  r_state;
  logic [15:0] r_t0, r_gain;
  logic [31:0] r_worst, r_din, r_a, r_e;
  logic [1:0]  r_idx;
  logic        r_pass2;

  logic        w_short;
  logic [1:0]  w_z1, w_z2;
  logic [31:0] w_opnd, w_e;

  // Zone bounds are only meaningful when the lag is not short.
  assign w_short = (r_t0 < L_SUBFR);
  assign w_z1    = zone_of(r_t0 - L_SUBFR);
  assign w_z2    = zone_of(r_t0 - 16'd1);
  assign w_opnd  = r_pass2 ? r_a : r_din;

  exc_err_calc u_calc (
    .i_x    (w_opnd),
    .i_gain (r_gain),
    .o_e    (w_e)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_t0    <= '0;
      r_gain  <= '0;
      r_worst <= '0;
      r_din   <= '0;
      r_a     <= '0;
      r_e     <= '0;
      r_idx   <= '0;
      r_pass2 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_t0    <= T0;
          r_gain  <= gain_pit;
          r_state <= S_INIT;
        end
        S_INIT: begin
          r_worst <= '1;
          r_pass2 <= 1'b0;
          r_idx   <= w_short ? 2'd0 : w_z1;
          r_state <= S_RD;
        end
        S_RD:   r_state <= S_WAIT;
        S_WAIT: begin
          r_din   <= memIn;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_e     <= w_e;
          r_state <= S_CMP;
        end
        S_CMP: begin
          if ($signed(r_e) > $signed(r_worst)) r_worst <= r_e;
          // Short lag: second pass feeds the first score back without a read.
          if (w_short && !r_pass2) begin
            r_a     <= r_e;
            r_pass2 <= 1'b1;
            r_state <= S_CALC;
          end else if (!w_short && (r_idx != w_z2)) begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_RD;
          end else begin
            r_idx   <= 2'd3;
            r_state <= S_SH_RD;
          end
        end
        S_SH_RD:   r_state <= S_SH_WAIT;
        S_SH_WAIT: begin
          r_din   <= memIn;
          r_state <= S_SH_WR;
        end
        S_SH_WR: begin
          r_idx   <= r_idx - 2'd1;
          r_state <= (r_idx == 2'd1) ? S_FIN : S_SH_RD;
        end
        S_FIN:  r_state <= S_DONE;
        S_DONE: if (!start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset forces them to zero.
  always_comb begin
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    case (r_state)
      S_RD:    memReadAddr = L_EXC_ERR + {10'd0, r_idx};
      S_SH_RD: memReadAddr = L_EXC_ERR + {10'd0, r_idx - 2'd1};
      S_SH_WR: begin
        memWriteEn   = 1'b1;
        memWriteAddr = L_EXC_ERR + {10'd0, r_idx};
        memOut       = r_din;
      end
      S_FIN: begin
        memWriteEn   = 1'b1;
        memWriteAddr = L_EXC_ERR;
        memOut       = r_worst;
      end
      default: ;
    endcase
  end

  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_update_exc_err.sv
// Bench for update_exc_err: directed vectors, mid-update reset, and a long
// randomised run checked against an independent basic_op model.
module tb_update_exc_err;
  import update_exc_err_pkg::*;

  localparam logic [11:0] BASE = L_EXC_ERR;
  localparam longint MAXL = 64'sh7FFF_FFFF;
  localparam longint MINL = -64'sh8000_0000;

  logic        clock, reset, start, done;
  logic [15:0] T0, gain_pit;
  logic [11:0] memReadAddr, memWriteAddr;
  logic [31:0] memIn, memOut;
  logic        memWriteEn;

  update_exc_err dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .T0(T0), .gain_pit(gain_pit),
    .memReadAddr(memReadAddr), .memIn(memIn),
    .memWriteAddr(memWriteAddr), .memOut(memOut), .memWriteEn(memWriteEn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] ram [4];
  logic        ld_en;
  logic [1:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clock) begin
    if (ld_en) ram[ld_idx] <= ld_val;
    else if (memWriteEn && memWriteAddr >= BASE && memWriteAddr <= BASE + 12'd3)
      ram[2'(memWriteAddr - BASE)] <= memOut;
    if (memReadAddr >= BASE && memReadAddr <= BASE + 12'd3)
      memIn <= ram[2'(memReadAddr - BASE)];
    else
      memIn <= 32'hBAD0_BAD0;
  end

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [15:0] t0; logic [15:0] g;
    logic [3:0][31:0] wi; logic [3:0][31:0] we;
  } vec_t;

  wr_t sb[$];
  logic [3:0][31:0] mdl;
  int checks = 0, failures = 0, n_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic longint sat32m(longint v);
    if (v > MAXL) return MAXL;
    if (v < MINL) return MINL;
    return v;
  endfunction
  function automatic longint sat16m(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction
  function automatic longint lmult(longint a, longint b);
    if (a == -32768 && b == -32768) return MAXL;
    return a * b * 2;
  endfunction
  function automatic longint mult16(longint a, longint b);
    return sat16m((a * b) >>> 15);
  endfunction
  function automatic longint ext_l(longint v);
    longint t;
    t = v & 64'hFFFF;
    if (t > 32767) t = t - 65536;
    return t;
  endfunction

  function automatic longint e_model(longint x, logic [15:0] g);
    longint gg, hi, lo, l;
    gg = longint'($signed(g));
    hi = x >>> 16;
    lo = ext_l(sat32m((x >>> 1) - lmult(hi, 16384)));
    l  = lmult(hi, gg);
    l  = sat32m(l + lmult(mult16(lo, gg), 1));
    l  = sat32m(l * 2);
    return sat32m(l + 16384);
  endfunction

  function automatic int zn(int k);
    return (k / 40 > 3) ? 3 : k / 40;
  endfunction

  function automatic logic [31:0] model_worst(int t0, logic [15:0] g);
    longint w, a, b;
    w = -1;
    if (t0 < 40) begin
      a = e_model(longint'($signed(mdl[0])), g);
      b = e_model(a, g);
      if (a > w) w = a;
      if (b > w) w = b;
    end else begin
      for (int i = zn(t0 - 40); i <= zn(t0 - 1); i++) begin
        a = e_model(longint'($signed(mdl[i])), g);
        if (a > w) w = a;
      end
    end
    return 32'(w);
  endfunction

  // Reader side of the array: the taboo-lag check on an integer lag.
  function automatic logic taboo(int t0, logic [3:0][31:0] arr);
    longint mx;
    int i1;
    mx = -1;
    i1 = (t0 - 50 < 0) ? 0 : t0 - 50;
    for (int i = zn(t0 + 8); i >= zn(i1); i--)
      if (longint'($signed(arr[i])) > mx) mx = longint'($signed(arr[i]));
    return mx > 64'sd983040000;
  endfunction

  function automatic logic [3:0][31:0] ram_pk();
    logic [3:0][31:0] p;
    for (int i = 0; i < 4; i++) p[i] = ram[i];
    return p;
  endfunction

  function automatic vec_t mk(logic [15:0] t0, logic [15:0] g,
                              logic [31:0] i0, logic [31:0] i1, logic [31:0] i2, logic [31:0] i3,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
    vec_t v;
    v.t0 = t0; v.g = g;
    v.wi[0] = i0; v.wi[1] = i1; v.wi[2] = i2; v.wi[3] = i3;
    v.we[0] = e0; v.we[1] = e1; v.we[2] = e2; v.we[3] = e3;
    return v;
  endfunction

  task automatic preload(input logic [3:0][31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ld_en = 1'b1; ld_idx = 2'(i); ld_val = w[i]; mdl[i] = w[i];
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic run_update(input logic [15:0] t0, input logic [15:0] g);
    logic [31:0] w;
    int lat;
    w = model_worst(int'(t0), g);
    sb.push_back('{addr: BASE + 12'd3, data: mdl[2]});
    sb.push_back('{addr: BASE + 12'd2, data: mdl[1]});
    sb.push_back('{addr: BASE + 12'd1, data: mdl[0]});
    sb.push_back('{addr: BASE,         data: w});
    mdl[3] = mdl[2]; mdl[2] = mdl[1]; mdl[1] = mdl[0]; mdl[0] = w;
    @(negedge clock);
    T0 = t0; gain_pit = g; start = 1'b1;
    @(negedge clock);
    T0 = 16'($urandom); gain_pit = 16'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    chk("done_high", 32'(done), 32'd1);
    checks++;
    if (lat > 32) begin
      failures++;
      $display("FAIL latency got=%0d want<=32", lat);
    end
    start = 1'b0;
    @(negedge clock);
    chk("done_clear", 32'(done), 32'd0);
    chk("writes_seen", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[6];
  int   n0;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; T0 = '0; gain_pit = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    vecs[0] = mk(16'd30,  16'h4000, 32'h4000, 32'h11, 32'h22, 32'h33,
                 32'h0000C000, 32'h4000, 32'h11, 32'h22);
    vecs[1] = mk(16'd100, 16'h4000, 32'h0, 32'h10000, 32'h20000, 32'h30000,
                 32'h00024000, 32'h0, 32'h10000, 32'h20000);
    vecs[2] = mk(16'd143, 16'h7FFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    vecs[3] = mk(16'd50,  16'h0000, 32'h12345678, 32'h80000000, 32'hDEADBEEF, 32'h1,
                 32'h00004000, 32'h12345678, 32'h80000000, 32'hDEADBEEF);
    vecs[4] = mk(16'd40,  16'h4000, 32'h80000000, 32'h1, 32'h2, 32'h3,
                 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h2);
    vecs[5] = mk(16'hFFFF, 16'h4000, 32'h0, 32'h0, 32'h0, 32'h10000,
                 32'h00014000, 32'h0, 32'h0, 32'h0);

    repeat (3) @(negedge clock);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_we",    32'(memWriteEn), 32'd0);
    chk("rst_raddr", 32'(memReadAddr), 32'd0);
    chk("rst_waddr", 32'(memWriteAddr), 32'd0);
    chk("rst_dout",  memOut, 32'd0);
    reset = 1'b1;

    fork
      forever begin
        wr_t e;
        @(negedge clock);
        if (memWriteEn) begin
          n_wr++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write addr=%h data=%h", memWriteAddr, memOut);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(memWriteAddr), 32'(e.addr));
            chk("wr_data", memOut, e.data);
          end
        end
      end
    join_none

    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].wi);
      run_update(vecs[v].t0, vecs[v].g);
      for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_w%0d", v, i), ram[i], vecs[v].we[i]);
      chk("vec_taboo", 32'(taboo(int'(vecs[v].t0), ram_pk())), 32'(taboo(int'(vecs[v].t0), mdl)));
    end

    // Reset five cycles into an update: no writes, outputs forced to zero.
    preload({32'h30000, 32'h20000, 32'h10000, 32'h0});
    @(negedge clock);
    T0 = 16'd100; gain_pit = 16'h4000; start = 1'b1;
    repeat (5) @(negedge clock);
    n0 = n_wr;
    reset = 1'b0; start = 1'b0;
    #1;
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_we",    32'(memWriteEn), 32'd0);
    chk("abort_raddr", 32'(memReadAddr), 32'd0);
    chk("abort_waddr", 32'(memWriteAddr), 32'd0);
    chk("abort_dout",  memOut, 32'd0);
    repeat (3) @(negedge clock);
    chk("abort_nowr", 32'(n_wr - n0), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_idle", 32'(done), 32'd0);
    run_update(16'd100, 16'h4000);
    chk("restart_w0", ram[0], 32'h00024000);
    chk("restart_w1", ram[1], 32'h0);
    chk("restart_w3", ram[3], 32'h20000);

    preload({32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
    for (int n = 0; n < 256; n++) begin
      logic [15:0] t0r, gr;
      t0r = 16'($urandom_range(20, 143));
      gr  = 16'($urandom);
      run_update(t0r, gr);
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d_w%0d", n, i), ram[i], mdl[i]);
      chk($sformatf("rnd%0d_taboo", n), 32'(taboo(int'(t0r), ram_pk())), 32'(taboo(int'(t0r), mdl)));
    end

    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
